// File: rtl/bitband_rmw_sequencer.sv
// Bit-band read-modify-write sequencer between the core LSU data port and the
// peripheral controller. Alias-region accesses become a word read plus a
// single-bit extract (reads) or a word read, bit merge and word write
// (writes); every other request is passed straight through. Only one
// transaction is outstanding at any time.
//
// Ports:
//   clk, rst_n                  core clock, synchronous active-low reset
//   data_req_i .. data_rdata_o  core LSU side (req/gnt, rvalid response)
//   periph_req_o .. periph_rdata_i  peripheral controller side (req/gnt, rvalid)
//   is_bitbanded_o              current peripheral access comes from the alias
//   busy_o                      sequencer is not idle
module bitband_rmw_sequencer #(
  parameter logic [31:0] BB_BASE     = 32'h0A00_0000,
  parameter logic [31:0] BB_SIZE     = 32'h0002_0000,
  parameter logic [31:0] PERIPH_BASE = 32'h0080_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        periph_req_o,
  output logic        periph_we_o,
  output logic [31:0] periph_addr_o,
  output logic [31:0] periph_wdata_o,
  input  logic        periph_gnt_i,
  input  logic        periph_rvalid_i,
  input  logic [31:0] periph_rdata_i,
  output logic        is_bitbanded_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PT_WAIT = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    WR_REQ  = 3'd4,
    WR_WAIT = 3'd5,
    RESP    = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic [31:0] off;
  logic [31:0] tgt_byte;
  logic [31:0] word_addr;
  logic [4:0]  bit_idx;
  logic        alias_hit;
  logic        unused_off;

  logic [31:0] addr_q;
  logic [31:0] word_q;
  logic [4:0]  idx_q;
  logic        we_q;
  logic        bit_q;

  logic [31:0] bit_mask;
  logic [31:0] merged_word;

  // Comparing the offset against the size avoids overflow of BB_BASE+BB_SIZE.
  assign off       = data_addr_i - BB_BASE;
  assign alias_hit = (data_addr_i >= BB_BASE) && (off < BB_SIZE);

  // Each alias word stands for one peripheral bit: off[31:5] selects the
  // peripheral byte, off[4:2] the bit within that byte.
  assign tgt_byte   = PERIPH_BASE + {5'b0, off[31:5]};
  assign word_addr  = {tgt_byte[31:2], 2'b00};
  assign bit_idx    = {tgt_byte[1:0], off[4:2]};
  // Byte lane within the alias word carries no meaning.
  assign unused_off = ^off[1:0];

  assign bit_mask    = 32'd1 << idx_q;
  assign merged_word = bit_q ? (word_q | bit_mask) : (word_q & ~bit_mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      word_q <= '0;
      idx_q  <= '0;
      we_q   <= 1'b0;
      bit_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && data_req_i && alias_hit) begin
        addr_q <= word_addr;
        idx_q  <= bit_idx;
        we_q   <= data_we_i;
        bit_q  <= data_wdata_i[0];
      end
      if (state == RD_WAIT && periph_rvalid_i) begin
        word_q <= periph_rdata_i;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    data_gnt_o     = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    periph_req_o   = 1'b0;
    periph_we_o    = 1'b0;
    periph_addr_o  = '0;
    periph_wdata_o = '0;
    is_bitbanded_o = 1'b0;
    busy_o         = (state != IDLE);

    unique case (state)
      IDLE: begin
        if (data_req_i) begin
          if (alias_hit) begin
            // Alias requests are accepted at once; the peripheral side is
            // driven from the latched copy starting next cycle.
            data_gnt_o = 1'b1;
            state_nxt  = RD_REQ;
          end else begin
            periph_req_o   = 1'b1;
            periph_we_o    = data_we_i;
            periph_addr_o  = data_addr_i;
            periph_wdata_o = data_wdata_i;
            data_gnt_o     = periph_gnt_i;
            if (periph_gnt_i) begin
              state_nxt = PT_WAIT;
            end
          end
        end
      end

      PT_WAIT: begin
        data_rvalid_o = periph_rvalid_i;
        data_rdata_o  = periph_rdata_i;
        if (periph_rvalid_i) begin
          state_nxt = IDLE;
        end
      end

      RD_REQ: begin
        periph_req_o   = 1'b1;
        periph_addr_o  = addr_q;
        is_bitbanded_o = 1'b1;
        if (periph_gnt_i) begin
          state_nxt = RD_WAIT;
        end
      end

      RD_WAIT: begin
        periph_addr_o  = addr_q;
        is_bitbanded_o = 1'b1;
        if (periph_rvalid_i) begin
          state_nxt = we_q ? WR_REQ : RESP;
        end
      end

      WR_REQ: begin
        periph_req_o   = 1'b1;
        periph_we_o    = 1'b1;
        periph_addr_o  = addr_q;
        periph_wdata_o = merged_word;
        is_bitbanded_o = 1'b1;
        if (periph_gnt_i) begin
          state_nxt = WR_WAIT;
        end
      end

      WR_WAIT: begin
        periph_addr_o  = addr_q;
        is_bitbanded_o = 1'b1;
        if (periph_rvalid_i) begin
          state_nxt = RESP;
        end
      end

      RESP: begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = we_q ? 32'd0 : {31'b0, word_q[idx_q]};
        state_nxt     = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bitband_rmw_sequencer.sv
module tb_bitband_rmw_sequencer;

  localparam logic [31:0] BB_BASE     = 32'h0A00_0000;
  localparam logic [31:0] BB_SIZE     = 32'h0002_0000;
  localparam logic [31:0] PERIPH_BASE = 32'h0080_0000;
  localparam logic [31:0] WR_RESP     = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        periph_req_o;
  logic        periph_we_o;
  logic [31:0] periph_addr_o;
  logic [31:0] periph_wdata_o;
  logic        periph_gnt_i = 1'b0;
  logic        periph_rvalid_i = 1'b0;
  logic [31:0] periph_rdata_i = '0;
  logic        is_bitbanded_o;
  logic        busy_o;

  bitband_rmw_sequencer #(
    .BB_BASE(BB_BASE), .BB_SIZE(BB_SIZE), .PERIPH_BASE(PERIPH_BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_we_i(data_we_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o),
    .periph_req_o(periph_req_o), .periph_we_o(periph_we_o),
    .periph_addr_o(periph_addr_o), .periph_wdata_o(periph_wdata_o),
    .periph_gnt_i(periph_gnt_i), .periph_rvalid_i(periph_rvalid_i),
    .periph_rdata_i(periph_rdata_i),
    .is_bitbanded_o(is_bitbanded_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bb;
  } ptxn_t;

  ptxn_t       exp_p[$];
  logic [31:0] exp_r[$];
  logic [31:0] pmem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F96;
  endfunction

  function automatic logic [31:0] pget(input logic [31:0] a);
    if (pmem.exists(a)) return pmem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] rget(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  task automatic pset(input logic [31:0] a, input logic [31:0] v);
    pmem[a] = v;
    ref_mem[a] = v;
  endtask

  function automatic bit is_alias(input logic [31:0] a);
    return (a >= BB_BASE) && ((a - BB_BASE) < BB_SIZE);
  endfunction

  // Each aliased word is one bit: alias word n is bit (n % 8) of peripheral
  // byte (n / 8); that byte sits at lane (byte % 4) of its word.
  task automatic model_issue(input bit we, input logic [31:0] a, input logic [31:0] wd);
    ptxn_t       t;
    int unsigned n;
    logic [31:0] tgt;
    logic [31:0] wa;
    int unsigned b;
    logic [31:0] w;
    if (is_alias(a)) begin
      n   = (a - BB_BASE) / 4;
      tgt = PERIPH_BASE + n / 8;
      wa  = tgt & ~32'h3;
      b   = (tgt % 4) * 8 + n % 8;
      w   = rget(wa);
      t   = '{we: 1'b0, addr: wa, wdata: 32'd0, bb: 1'b1};
      exp_p.push_back(t);
      if (we) begin
        w[b] = wd[0];
        ref_mem[wa] = w;
        t = '{we: 1'b1, addr: wa, wdata: w, bb: 1'b1};
        exp_p.push_back(t);
        exp_r.push_back(32'd0);
      end else begin
        exp_r.push_back((w >> b) & 32'd1);
      end
    end else begin
      t = '{we: we, addr: a, wdata: wd, bb: 1'b0};
      exp_p.push_back(t);
      if (we) begin
        ref_mem[a] = wd;
        exp_r.push_back(WR_RESP);
      end else begin
        exp_r.push_back(rget(a));
      end
    end
  endtask

  // ---------------- peripheral responder ----------------
  int          fixed_wait = -1;
  int          fixed_rv = 0;
  bit          block_wr = 1'b0;
  bit          armed = 1'b0;
  int          wait_left = 0;
  bit          pend = 1'b0;
  int          rv_left = 0;
  logic [31:0] pend_data = '0;

  always begin
    @(negedge clk);
    #1;
    periph_rvalid_i = 1'b0;
    periph_gnt_i = 1'b0;
    if (!rst_n) begin
      armed = 1'b0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        rv_left--;
        if (rv_left == 0) begin
          periph_rvalid_i = 1'b1;
          periph_rdata_i = pend_data;
          pend = 1'b0;
        end
      end
      if (periph_req_o && !pend && !(block_wr && periph_we_o)) begin
        if (!armed) begin
          armed = 1'b1;
          wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 2);
        end
        if (wait_left == 0) begin
          periph_gnt_i = 1'b1;
          armed = 1'b0;
          pend = 1'b1;
          rv_left = (fixed_rv > 0) ? fixed_rv : $urandom_range(1, 3);
          if (periph_we_o) begin
            pmem[periph_addr_o] = periph_wdata_o;
            pend_data = WR_RESP;
          end else begin
            pend_data = pget(periph_addr_o);
          end
        end else begin
          wait_left--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int rv_count = 0;
  int last_rv_cyc = 0;

  always begin
    ptxn_t t;
    @(negedge clk);
    #3;
    if (rst_n) begin
      if (data_rvalid_o) begin
        rv_count++;
        last_rv_cyc = cyc;
        if (exp_r.size() == 0) fail("unexpected_rvalid");
        else check("core_rdata", data_rdata_o, exp_r.pop_front());
      end
      if (periph_req_o && periph_gnt_i) begin
        if (exp_p.size() == 0) begin
          fail("unexpected_periph_access");
        end else begin
          t = exp_p.pop_front();
          check("periph_we", {31'b0, periph_we_o}, {31'b0, t.we});
          check("periph_addr", periph_addr_o, t.addr);
          check("is_bitbanded", {31'b0, is_bitbanded_o}, {31'b0, t.bb});
          if (t.we) check("periph_wdata", periph_wdata_o, t.wdata);
        end
      end
      if (busy_o) check("gnt_while_busy", {31'b0, data_gnt_o}, 32'd0);
      if (!busy_o && data_req_i) begin
        if (is_alias(data_addr_i)) begin
          check("alias_gnt", {31'b0, data_gnt_o}, 32'd1);
          check("alias_no_periph_req", {31'b0, periph_req_o}, 32'd0);
        end else begin
          check("pt_gnt_tracks", {31'b0, data_gnt_o}, {31'b0, periph_gnt_i});
          check("pt_req", {31'b0, periph_req_o}, 32'd1);
          check("pt_addr", periph_addr_o, data_addr_i);
        end
      end
    end
  end

  // ---------------- core driver ----------------
  int gnt_cyc = 0;
  int start_cyc = 0;

  // Called on a negedge; returns on the negedge after the grant with req low.
  task automatic core_req(input bit we, input logic [31:0] a, input logic [31:0] wd);
    bit got;
    model_issue(we, a, wd);
    data_req_i = 1'b1;
    data_we_i = we;
    data_addr_i = a;
    data_wdata_i = wd;
    start_cyc = cyc;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      #3;
      if (data_gnt_o) begin
        got = 1'b1;
        gnt_cyc = cyc;
      end
      @(negedge clk);
    end
    if (!got) fail("core_gnt_timeout");
    data_req_i = 1'b0;
    data_we_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_r.size() == 0 && exp_p.size() == 0 && !busy_o) done = 1'b1;
    end
    if (!done) fail("drain_timeout");
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          n0;
    int          g0;
    bit          hit;
    logic [31:0] a;
    logic [31:0] bounds [5];

    repeat (3) @(negedge clk);
    #3;
    check("rst_gnt", {31'b0, data_gnt_o}, 32'd0);
    check("rst_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    check("rst_rdata", data_rdata_o, 32'd0);
    check("rst_preq", {31'b0, periph_req_o}, 32'd0);
    check("rst_pwe", {31'b0, periph_we_o}, 32'd0);
    check("rst_paddr", periph_addr_o, 32'd0);
    check("rst_pwdata", periph_wdata_o, 32'd0);
    check("rst_bb", {31'b0, is_bitbanded_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bit-band read, zero-wait peripheral.
    fixed_wait = 0;
    fixed_rv = 1;
    pset(32'h0080_0100, 32'h0000_0008);
    n0 = rv_count;
    core_req(1'b0, 32'h0A00_200C, 32'd0);
    wait_idle();
    check("bb_rd_latency", last_rv_cyc - gnt_cyc, 32'd3);
    check("bb_rd_rvalid_once", rv_count - n0, 32'd1);

    // Bit-band set and clear of bit 21.
    pset(32'h0080_0100, 32'h0000_0000);
    core_req(1'b1, 32'h0A00_2054, 32'd1);
    wait_idle();
    check("bb_set_word", pget(32'h0080_0100), 32'h0020_0000);
    pset(32'h0080_0100, 32'hFFFF_FFFF);
    core_req(1'b1, 32'h0A00_2054, 32'hFFFF_FFFE);
    wait_idle();
    check("bb_clr_word", pget(32'h0080_0100), 32'hFFDF_FFFF);

    // Pass-through with grant held off two cycles.
    fixed_wait = 2;
    fixed_rv = 2;
    core_req(1'b0, 32'h0080_0200, 32'd0);
    check("pt_gnt_delay", gnt_cyc - start_cyc, 32'd2);
    wait_idle();

    // Alias write followed at once by a held pass-through read of that word.
    fixed_wait = 0;
    fixed_rv = 1;
    core_req(1'b1, 32'h0A00_2058, 32'd1);
    g0 = gnt_cyc;
    core_req(1'b0, 32'h0080_0100, 32'd0);
    check("b2b_gnt_gap", gnt_cyc - g0, 32'd6);
    wait_idle();

    // Reset while the write half of an RMW is pending.
    block_wr = 1'b1;
    pset(32'h0080_0100, 32'h1234_5678);
    core_req(1'b1, 32'h0A00_2054, 32'd1);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      #3;
      if (periph_req_o && periph_we_o) hit = 1'b1;
      @(negedge clk);
    end
    if (!hit) fail("wr_req_timeout");
    rst_n = 1'b0;
    @(negedge clk);
    #3;
    check("rst_mid_preq", {31'b0, periph_req_o}, 32'd0);
    check("rst_mid_busy", {31'b0, busy_o}, 32'd0);
    exp_p.delete();
    exp_r.delete();
    ref_mem[32'h0080_0100] = 32'h1234_5678;
    @(negedge clk);
    rst_n = 1'b1;
    block_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      check("rst_mid_no_rvalid", {31'b0, data_rvalid_o}, 32'd0);
      @(negedge clk);
    end
    check("rst_mid_no_write", pget(32'h0080_0100), 32'h1234_5678);

    // Randomized traffic.
    fixed_wait = -1;
    fixed_rv = 0;
    bounds[0] = BB_BASE - 32'd4;
    bounds[1] = BB_BASE;
    bounds[2] = BB_BASE + BB_SIZE - 32'd1;
    bounds[3] = BB_BASE + BB_SIZE - 32'd4;
    bounds[4] = BB_BASE + BB_SIZE;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = BB_BASE + $urandom_range(0, 8191);
        4, 5:       a = BB_BASE + $urandom_range(0, 32'h1_FFFF);
        6, 7, 8:    a = PERIPH_BASE + ($urandom_range(0, 63) << 2);
        default:    a = bounds[$urandom_range(0, 4)];
      endcase
      core_req($urandom_range(0, 1) == 1, a, $urandom);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    check("exp_resp_left", exp_r.size(), 32'd0);
    check("exp_periph_left", exp_p.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
